seq_alu: RTL and testbench

//  Parametrised multi-cycle ALU, successor to the combinational add/sub/mul breadboard ALU.

---
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu.sv | 192 +++++++++++++++++++
 tb/tb_seq_alu.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Command/result bundle between the command sequencer and seq_alu.
// The sequencer is the master; the ALU is the slave.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [3:0]           command;
    logic [WIDTH-1:0]     inputA;
    logic [WIDTH-1:0]     inputB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 error;

    modport master (
        output start, command, inputA, inputB,
        input  busy, done, result, error
    );

    modport slave (
        input  start, command, inputA, inputB,
        output busy, done, result, error
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub, shift-add multiply, restoring divide/modulo.
// One operation in flight; start/busy/done handshake through seq_alu_if.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE, EXEC, MUL, DIV, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     wrk_q, wrk_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 sub_mode;
    logic [WIDTH-1:0]     b_x;
    logic [WIDTH:0]       sum_full;
    logic [WIDTH-1:0]     sum;
    logic                 c_msb;
    logic                 ovf;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;

    // Adder: B inverted with carry-in for subtract; overflow from MSB carries
    always_comb begin
        sub_mode = (cmd_q == 4'd2);
        b_x      = b_q ^ {WIDTH{sub_mode}};
        sum_full = {1'b0, a_q} + {1'b0, b_x}
                 + {{WIDTH{1'b0}}, sub_mode};
        sum      = sum_full[WIDTH-1:0];
        c_msb    = a_q[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1];
        ovf      = sum_full[WIDTH] ^ c_msb;
    end

    // Restoring divide step: shift next dividend bit in, trial-subtract B
    always_comb begin
        rem_sh = {rem_q, wrk_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, b_q};
    end

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        wrk_d    = wrk_q;
        rem_d    = rem_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        res_d    = res_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cmd_d = bus.command;
                    a_d   = bus.inputA;
                    b_d   = bus.inputB;
                    cnt_d = '0;
                    if (bus.command == 4'd3) begin
                        state_d = MUL;
                    end else if ((bus.command == 4'd4 ||
                                  bus.command == 4'd5) &&
                                 bus.inputB != '0) begin
                        state_d = DIV;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                bus.busy = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (cmd_q == 4'd1 || cmd_q == 4'd2) begin
                        res_d = {{WIDTH{sum[WIDTH-1]}}, sum};
                        err_d = ovf;
                    end else if (cmd_q == 4'd0) begin
                        res_d = '0;
                        err_d = 1'b0;
                    end else begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MUL: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    prod_d  = '0;
                    mcand_d = {{WIDTH{1'b0}}, a_q};
                    wrk_d   = b_q;
                    cnt_d   = cnt_q + CW'(1);
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    res_d   = prod_q;
                    err_d   = 1'b0;
                end else begin
                    if (wrk_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    wrk_d   = wrk_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DIV: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    rem_d = '0;
                    wrk_d = a_q;
                    cnt_d = cnt_q + CW'(1);
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (cmd_q == 4'd4) begin
                        res_d = {{WIDTH{1'b0}}, wrk_q};
                    end else begin
                        res_d = {{WIDTH{1'b0}}, rem_q};
                    end
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.result = res_q;
    assign bus.error  = err_q;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wrk_q   <= '0;
            rem_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wrk_q   <= wrk_d;
            rem_q   <= rem_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16 and WIDTH=8.
// Checks latency, handshake, results, error flag and async reset.
module tb_seq_alu;
    logic clk;
    logic rst;
    int   ntests;
    int   nfail;

    seq_alu_if #(.WIDTH(16)) if16 ();
    seq_alu_if #(.WIDTH(8))  if8 ();

    seq_alu #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic s,
                         input logic [3:0] cmd,
                         input logic [15:0] a,
                         input logic [15:0] b);
        if (w8) begin
            if8.start   = s;
            if8.command = cmd;
            if8.inputA  = a[7:0];
            if8.inputB  = b[7:0];
        end else begin
            if16.start   = s;
            if16.command = cmd;
            if16.inputA  = a;
            if16.inputB  = b;
        end
    endtask

    function automatic logic get_busy(input bit w8);
        return w8 ? if8.busy : if16.busy;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? if8.done : if16.done;
    endfunction

    function automatic logic get_err(input bit w8);
        return w8 ? if8.error : if16.error;
    endfunction

    function automatic logic [31:0] get_res(input bit w8);
        return w8 ? {16'h0, if8.result} : if16.result;
    endfunction

    // Launch one op, scramble operands after accept, optionally pulse
    // a second start mid-flight, then also try a start in the done cycle.
    task automatic run_op(input bit w8, input logic [3:0] cmd,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat,
                          input bit inject, input string tag);
        int k;
        @(negedge clk);
        drive(w8, 1'b1, cmd, a, b);
        @(posedge clk);
        #1;
        check({tag, "/busy_acc"}, 64'(get_busy(w8)), 64'd1);
        @(negedge clk);
        drive(w8, 1'b0, ~cmd, ~a, b + 16'd3);
        k = 0;
        while (!get_done(w8) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (inject && k == 3) drive(w8, 1'b1, 4'd1, 16'd1, 16'd1);
            if (inject && k == 4) drive(w8, 1'b0, 4'd0, 16'd0, 16'd0);
        end
        check({tag, "/latency"}, 64'(k), 64'(exp_lat));
        check({tag, "/busy_done"}, 64'(get_busy(w8)), 64'd0);
        check({tag, "/result"}, 64'(get_res(w8)), 64'(exp_res));
        check({tag, "/error"}, 64'(get_err(w8)), 64'(exp_err));
        drive(w8, 1'b1, 4'd1, 16'd5, 16'd6);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, 4'd0, 16'd0, 16'd0);
        check({tag, "/done_pulse"}, 64'(get_done(w8)), 64'd0);
        check({tag, "/idle_after"}, 64'(get_busy(w8)), 64'd0);
        check({tag, "/held"}, 64'(get_res(w8)), 64'(exp_res));
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
        #1;
        check("rst16/busy", 64'(if16.busy), 64'd0);
        check("rst16/done", 64'(if16.done), 64'd0);
        check("rst16/result", 64'(if16.result), 64'd0);
        check("rst16/error", 64'(if16.error), 64'd0);
        check("rst8/busy", 64'(if8.busy), 64'd0);
        check("rst8/result", 64'(if8.result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 4'd1, 16'd249, 16'd69, 32'd318, 0, 2, 0, "add249");
        run_op(0, 4'd2, 16'd249, 16'd69, 32'd180, 0, 2, 0, "sub249");
        run_op(0, 4'd3, 16'd249, 16'd69, 32'd17181, 0, 18, 0, "mul249");

        run_op(0, 4'd1, 16'h7D00, 16'h3E81, 32'hFFFFBB81, 1, 2, 0, "add_ovf");
        run_op(0, 4'd2, 16'h7D00, 16'h3E81, 32'h00003E7F, 0, 2, 0, "sub_big");
        run_op(0, 4'd3, 16'h7D00, 16'h3E81, 32'd512032000, 0, 18, 0, "mul_big");
        run_op(0, 4'd2, 16'h8000, 16'h0001, 32'h00007FFF, 1, 2, 0, "sub_ovf");
        run_op(0, 4'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 18, 0, "mul_max");

        run_op(0, 4'd4, 16'd249, 16'd69, 32'd3, 0, 18, 0, "div249");
        run_op(0, 4'd5, 16'd249, 16'd69, 32'd42, 0, 18, 0, "mod249");
        run_op(0, 4'd4, 16'hFFFF, 16'd1, 32'd65535, 0, 18, 0, "div_by1");
        run_op(0, 4'd5, 16'hFFFF, 16'h0100, 32'h000000FF, 0, 18, 0, "mod_256");
        run_op(0, 4'd4, 16'd249, 16'd0, 32'd0, 1, 2, 0, "div_zero");
        run_op(0, 4'd5, 16'd249, 16'd0, 32'd0, 1, 2, 0, "mod_zero");

        run_op(0, 4'd3, 16'd249, 16'd69, 32'd17181, 0, 18, 1, "mul_inject");
        run_op(0, 4'd9, 16'd249, 16'd69, 32'd0, 1, 2, 0, "illegal9");
        run_op(0, 4'd0, 16'd249, 16'd69, 32'd0, 0, 2, 0, "nop");
        run_op(0, 4'd3, 16'd300, 16'd7, 32'd2100, 0, 18, 0, "mul_pre_rst");

        @(negedge clk);
        drive(0, 1'b1, 4'd4, 16'd1000, 16'd7);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 16'd0, 16'd0);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst/busy", 64'(if16.busy), 64'd0);
        check("midrst/done", 64'(if16.done), 64'd0);
        check("midrst/result", 64'(if16.result), 64'd0);
        check("midrst/error", 64'(if16.error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("midrst/no_stale_done", 64'(if16.done), 64'd0);
        end
        run_op(0, 4'd1, 16'd2, 16'd3, 32'd5, 0, 2, 0, "add_after_rst");

        run_op(1, 4'd3, 16'd200, 16'd200, 32'd40000, 0, 10, 0, "w8_mul");
        run_op(1, 4'd1, 16'd100, 16'd100, 32'h0000FFC8, 1, 2, 0, "w8_add");
        run_op(1, 4'd4, 16'd200, 16'd7, 32'd28, 0, 10, 0, "w8_div");
        run_op(1, 4'd5, 16'd200, 16'd7, 32'd4, 0, 10, 0, "w8_mod");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
